fetch_stage: RTL

//   IF stage of the 5-stage RV32I pipeline. Owns the PC register and the IF/ID pipeline register.

---
 rtl/if_pkg.sv | 26 ++
 rtl/fetch_stage_if.sv | 33 +++
 rtl/if_id_reg.sv | 37 +++
 rtl/fetch_stage.sv | 120 ++++++++++++
 4 files changed

// File: rtl/if_pkg.sv
// Shared types and constants for the RV32I fetch stage.
// Exports PC_W, NOP_I, the fetch FSM state enum, the IF/ID record type and a redirect-target helper.
// No ports; pure declarations.
package if_pkg;

  parameter int unsigned PC_W = 9;

  // addi x0,x0,0 -- the canonical bubble
  localparam logic [31:0] NOP_I = 32'h0000_0013;

  typedef enum logic {IF_RUN, IF_HALT} if_state_e;

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic [31:0]     instr;
    logic            valid;
  } if_id_t;

  localparam if_id_t IF_ID_BUBBLE = '{pc: '0, instr: NOP_I, valid: 1'b0};

  // Redirect targets are forced to word alignment; upper bits beyond the PC span are dropped.
  function automatic logic [PC_W-1:0] align_pc(input logic [31:0] addr);
    return {addr[PC_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Handshake/bus bundle between the fetch stage and its neighbours (branch unit, hazard unit, imem, decode).
// master: the environment driving redirect/stall/halt/instr and observing fetch outputs.
// slave : the fetch stage itself.
interface fetch_stage_if;
  import if_pkg::*;

  logic            pc_sel_i;
  logic [31:0]     br_pc_i;
  logic            stall_i;
  logic            halt_i;
  logic [31:0]     instr_i;
  logic [PC_W-1:0] pc_o;
  logic [PC_W-1:0] if_id_pc_o;
  logic [31:0]     if_id_instr_o;
  logic            if_id_valid_o;
  logic            halted_o;
  logic            misalign_o;
  logic [31:0]     fetch_cnt_o;
  logic [31:0]     flush_cnt_o;

  modport master (
    output pc_sel_i, br_pc_i, stall_i, halt_i, instr_i,
    input  pc_o, if_id_pc_o, if_id_instr_o, if_id_valid_o,
           halted_o, misalign_o, fetch_cnt_o, flush_cnt_o
  );

  modport slave (
    input  pc_sel_i, br_pc_i, stall_i, halt_i, instr_i,
    output pc_o, if_id_pc_o, if_id_instr_o, if_id_valid_o,
           halted_o, misalign_o, fetch_cnt_o, flush_cnt_o
  );

endinterface

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: loads a fetched record, holds, or is overwritten by a bubble.
// Ports: clk, rst_n (async active-low), load_i, bubble_i (wins over load_i), d_i, q_o.
// Latency 1 cycle; hold when neither control is asserted; reset value is the bubble.
module if_id_reg
  import if_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   load_i,
  input  logic   bubble_i,
  input  if_id_t d_i,
  output if_id_t q_o
);

  if_id_t q_q;
  if_id_t q_d;

  always_comb begin
    q_d = q_q;
    if (bubble_i) begin
      q_d = IF_ID_BUBBLE;
    end else if (load_i) begin
      q_d = d_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_q <= IF_ID_BUBBLE;
    end else begin
      q_q <= q_d;
    end
  end

  assign q_o = q_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage of the 5-stage RV32I pipeline: PC register, next-PC select, RUN/HALT FSM, IF/ID register.
// Ports: clk, rst_n (async active-low), bus (fetch_stage_if.slave: redirect/stall/halt/instr in,
//   pc/IF-ID/halted/misalign/perf counters out). All outputs are flops; redirect > halt > stall > advance.
// Optional macro IF_PERF_CNT_EN builds saturating fetch/flush counters; otherwise they read as 0.
module fetch_stage
  import if_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  fetch_stage_if.slave  bus
);

  logic [PC_W-1:0] pc_q, pc_d;
  if_state_e       state_q, state_d;
  logic            misalign_q, misalign_d;

  logic   ifid_load;
  logic   ifid_bubble;
  if_id_t ifid_d;
  if_id_t ifid_q;

  // Qualified events for this cycle; HALT masks every input.
  logic redirect;
  logic advance;

  always_comb begin
    redirect    = 1'b0;
    advance     = 1'b0;
    pc_d        = pc_q;
    state_d     = state_q;
    misalign_d  = 1'b0;
    ifid_load   = 1'b0;
    ifid_bubble = 1'b0;
    ifid_d      = '{pc: pc_q, instr: bus.instr_i, valid: 1'b1};

    if (state_q == IF_RUN) begin
      if (bus.pc_sel_i) begin
        // Redirect beats a same-cycle stall/halt: those came from wrong-path instructions.
        redirect    = 1'b1;
        pc_d        = align_pc(bus.br_pc_i);
        ifid_bubble = 1'b1;
        misalign_d  = |bus.br_pc_i[1:0];
      end else if (bus.halt_i) begin
        ifid_bubble = 1'b1;
        state_d     = IF_HALT;
      end else if (!bus.stall_i) begin
        advance     = 1'b1;
        pc_d        = pc_q + PC_W'(4);
        ifid_load   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q       <= '0;
      state_q    <= IF_RUN;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      state_q    <= state_d;
      misalign_q <= misalign_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load_i   (ifid_load),
    .bubble_i (ifid_bubble),
    .d_i      (ifid_d),
    .q_o      (ifid_q)
  );

`ifdef IF_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (advance && (fetch_cnt_q != 32'hFFFF_FFFF)) begin
      fetch_cnt_d = fetch_cnt_q + 32'd1;
    end
    if (redirect && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign bus.fetch_cnt_o = fetch_cnt_q;
  assign bus.flush_cnt_o = flush_cnt_q;
`else
  logic unused_cnt_events;
  assign unused_cnt_events = redirect ^ advance;
  assign bus.fetch_cnt_o   = 32'h0;
  assign bus.flush_cnt_o   = 32'h0;
`endif

  // Target bits above the PC span are intentionally dropped.
  logic unused_br_hi;
  assign unused_br_hi = ^bus.br_pc_i[31:PC_W];

  assign bus.pc_o          = pc_q;
  assign bus.if_id_pc_o    = ifid_q.pc;
  assign bus.if_id_instr_o = ifid_q.instr;
  assign bus.if_id_valid_o = ifid_q.valid;
  assign bus.halted_o      = (state_q == IF_HALT);
  assign bus.misalign_o    = misalign_q;

endmodule
